// File: rtl/word_pkg.sv
`default_nettype none
// ============================================================================
//  word_pkg -- shared FSM state encoding and character constants for the
//  word loader and its matcher.
//  Rev 1.0
// ============================================================================
package word_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_TERM  = 3'd2,
        ST_MATCH = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [7:0] c_nul           = 8'h00;
    localparam logic [7:0] c_delim_default = 8'h20;

endpackage
`default_nettype wire

// File: rtl/word_loader_if.sv
`default_nettype none
// ============================================================================
//  word_loader_if -- character stream, word-buffer write port, matcher
//  control and result handshake of the word loader.
//  Rev 1.0
// ============================================================================
interface word_loader_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  match_start;
    logic                  match_done;
    logic                  match_equal;

    logic                  res_valid;
    logic                  res_ready;
    logic                  res_hit;
    logic [ADDR_WIDTH-1:0] res_len;
    logic                  res_ovf;

    modport slave (
        input  in_valid, in_data, in_last, match_done, match_equal, res_ready,
        output in_ready, wr_en, wr_addr, wr_data, match_start,
               res_valid, res_hit, res_len, res_ovf
    );

    modport master (
        output in_valid, in_data, in_last, match_done, match_equal, res_ready,
        input  in_ready, wr_en, wr_addr, wr_data, match_start,
               res_valid, res_hit, res_len, res_ovf
    );
endinterface
`default_nettype wire

// File: rtl/word_loader.sv
`default_nettype none
// ============================================================================
//  word_loader -- tokenises a character stream into a NUL-terminated word
//  buffer, triggers the matcher and returns a hit/length/overflow result.
//  Rev 1.0
// ============================================================================
module word_loader
    import word_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] DELIM      = DATA_WIDTH'(c_delim_default)
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    word_loader_if.slave bus
);

    // Top slot is kept free so the terminator always fits.
    localparam logic [ADDR_WIDTH-1:0] c_ptr_max = '1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_ovf;
    logic                  r_in_ready;
    logic                  r_match_start;
    logic                  r_res_valid;
    logic                  r_res_hit;
    logic [ADDR_WIDTH-1:0] r_res_len;
    logic                  r_res_ovf;

    logic                  w_accept;
    logic                  w_is_delim;
    logic                  w_is_nul;
    logic                  w_has_room;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wr_data;

    assign w_accept   = bus.in_valid && r_in_ready;
    assign w_is_delim = (bus.in_data == DELIM);
    assign w_is_nul   = (bus.in_data == DATA_WIDTH'(c_nul));
    assign w_has_room = (r_ptr != c_ptr_max);

    // The SRAM write lands in the same cycle the character is accepted.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = bus.in_data;
        case (r_state)
            ST_IDLE: w_wr_en = w_accept && !w_is_delim && !w_is_nul;
            ST_FILL: w_wr_en = w_accept && !w_is_delim && w_has_room;
            ST_TERM: begin
                w_wr_en   = 1'b1;
                w_wr_data = DATA_WIDTH'(c_nul);
            end
            default: w_wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_ovf         <= 1'b0;
            r_in_ready    <= 1'b0;
            r_match_start <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_hit     <= 1'b0;
            r_res_len     <= '0;
            r_res_ovf     <= 1'b0;
        end else begin
            r_match_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept && !w_is_delim && !w_is_nul) begin
                        r_ptr <= ADDR_WIDTH'(1);
                        if (bus.in_last) begin
                            r_state    <= ST_TERM;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        if (!w_is_delim) begin
                            if (w_has_room) r_ptr <= r_ptr + ADDR_WIDTH'(1);
                            else            r_ovf <= 1'b1;
                        end
                        if (w_is_delim || bus.in_last) begin
                            r_state    <= ST_TERM;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_TERM: begin
                    r_state       <= ST_MATCH;
                    r_match_start <= 1'b1;
                end
                ST_MATCH: begin
                    if (bus.match_done) begin
                        r_res_hit   <= bus.match_equal && !r_ovf;
                        r_res_len   <= r_ptr;
                        r_res_ovf   <= r_ovf;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_ptr       <= '0;
                        r_ovf       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.wr_en       = w_wr_en;
    assign bus.wr_addr     = r_ptr;
    assign bus.wr_data     = w_wr_data;
    assign bus.match_start = r_match_start;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_hit     = r_res_hit;
    assign bus.res_len     = r_res_len;
    assign bus.res_ovf     = r_res_ovf;

endmodule
`default_nettype wire

// File: tb/tb_word_loader.sv
`default_nettype none
// ============================================================================
//  tb_word_loader -- scoreboard bench for word_loader.
//  Rev 1.0
// ============================================================================
module tb_word_loader;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic       hit;
        logic [3:0] len;
        logic       ovf;
    } res_t;

    logic clk;
    logic rst_n;

    word_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

    word_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DELIM(8'h20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    wr_t  sb_wr[$];
    res_t sb_res[$];

    // Reference model of the loader's pointer and overflow flag.
    bit       m_fill = 0;
    int       m_ptr  = 0;
    bit       m_ovf  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_wr(input int a, input logic [7:0] d);
        wr_t w;
        w.addr = 4'(a);
        w.data = d;
        sb_wr.push_back(w);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] c, input bit last);
        int t = 0;
        while (!bus.in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        if (!m_fill) begin
            if (c != 8'h20 && c != 8'h00) begin
                push_wr(0, c);
                m_ptr = 1;
                if (last) push_wr(m_ptr, 8'h00);
                else      m_fill = 1;
            end
        end else begin
            if (c != 8'h20) begin
                if (m_ptr != 15) begin
                    push_wr(m_ptr, c);
                    m_ptr++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (c == 8'h20 || last) begin
                push_wr(m_ptr, 8'h00);
                m_fill = 0;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = c;
        bus.in_last  = last;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic do_match(input bit equal, input int delay, input bit chk_lat);
        int   t = 0;
        res_t r;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.match_start && t < 60);
        if (chk_lat) chk("ms_latency", t, 2);
        else         chk("ms_seen", {31'd0, bus.match_start}, 1);
        if (!bus.match_start) return;
        @(negedge clk);
        chk("ms_pulse", {31'd0, bus.match_start}, 0);
        repeat (delay) @(posedge clk);
        @(posedge clk); #1;
        r.hit = equal && !m_ovf;
        r.len = 4'(m_ptr);
        r.ovf = m_ovf;
        sb_res.push_back(r);
        bus.match_done  = 1'b1;
        bus.match_equal = equal;
        @(posedge clk); #1;
        bus.match_done  = 1'b0;
        bus.match_equal = 1'b0;
        chk("res_latency", {31'd0, bus.res_valid}, 1);
    endtask

    task automatic take_result(input int hold);
        int t = 0;
        while (!bus.res_valid && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 60) begin
            chk("res_valid_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, bus.res_valid}, 1);
            chk("hold_in_ready", {31'd0, bus.in_ready}, 0);
            if (sb_res.size() > 0) begin
                chk("hold_len", {28'd0, bus.res_len}, {28'd0, sb_res[0].len});
                chk("hold_hit", {31'd0, bus.res_hit}, {31'd0, sb_res[0].hit});
            end
        end
        @(posedge clk); #1;
        m_ptr = 0;
        m_ovf = 0;
        m_fill = 0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk("post_resp_valid", {31'd0, bus.res_valid}, 0);
        chk("post_resp_in_ready", {31'd0, bus.in_ready}, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.wr_en) begin
            if (sb_wr.size() == 0) begin
                chk("wr_unexpected", {28'd0, bus.wr_addr}, 32'hFFFF);
            end else begin
                wr_t w;
                w = sb_wr.pop_front();
                chk("wr_addr", {28'd0, bus.wr_addr}, {28'd0, w.addr});
                chk("wr_data", {24'd0, bus.wr_data}, {24'd0, w.data});
            end
        end
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sb_res.size() == 0) begin
                chk("res_unexpected", {31'd0, bus.res_valid}, 0);
            end else begin
                res_t r;
                r = sb_res.pop_front();
                chk("res_hit", {31'd0, bus.res_hit}, {31'd0, r.hit});
                chk("res_len", {28'd0, bus.res_len}, {28'd0, r.len});
                chk("res_ovf", {31'd0, bus.res_ovf}, {31'd0, r.ovf});
            end
        end
    end

    initial begin
        logic [7:0] s_cat [4];
        logic [7:0] s_dog [5];
        int         t;

        s_cat = '{8'h63, 8'h61, 8'h74, 8'h20};
        s_dog = '{8'h20, 8'h20, 8'h64, 8'h6f, 8'h67};

        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = 8'h00;
        bus.in_last     = 1'b0;
        bus.match_done  = 1'b0;
        bus.match_equal = 1'b0;
        bus.res_ready   = 1'b0;

        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
        chk("rst_wr_en", {31'd0, bus.wr_en}, 0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 0);
        chk("rst_res_len", {28'd0, bus.res_len}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("in_ready_before_clk", {31'd0, bus.in_ready}, 0);
        @(posedge clk); #1;
        chk("in_ready_after_clk", {31'd0, bus.in_ready}, 1);

        // "cat " with a slow consumer
        for (int i = 0; i < 4; i++) send(s_cat[i], 1'b0);
        do_match(1'b1, 2, 1'b1);
        take_result(5);

        // "  dog" terminated by in_last
        for (int i = 0; i < 5; i++) send(s_dog[i], i == 4);
        do_match(1'b0, 0, 1'b1);
        take_result(0);

        // 20 characters overflow the buffer
        for (int i = 0; i < 20; i++) send(8'h7a, 1'b0);
        send(8'h20, 1'b0);
        do_match(1'b1, 1, 1'b1);
        take_result(1);

        // Stray match_done / res_ready while idle
        bus.match_done  = 1'b1;
        bus.match_equal = 1'b1;
        bus.res_ready   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_done_ignored", {31'd0, bus.res_valid}, 0);
        end
        @(posedge clk); #1;
        bus.match_done  = 1'b0;
        bus.match_equal = 1'b0;
        bus.res_ready   = 1'b0;
        @(negedge clk);
        chk("idle_still_no_res", {31'd0, bus.res_valid}, 0);
        @(posedge clk); #1;

        // Back-to-back words "a b "
        fork
            begin
                send(8'h61, 1'b0);
                send(8'h20, 1'b0);
                send(8'h62, 1'b0);
                send(8'h20, 1'b0);
            end
            begin
                do_match(1'b0, 0, 1'b0);
                take_result(0);
                do_match(1'b1, 0, 1'b0);
                take_result(0);
            end
        join

        // Reset while match_start is high abandons the token
        send(8'h78, 1'b0);
        send(8'h79, 1'b0);
        send(8'h20, 1'b0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.match_start && t < 60);
        chk("reset_ms_seen", {31'd0, bus.match_start}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_in_ready", {31'd0, bus.in_ready}, 0);
        chk("async_wr_en", {31'd0, bus.wr_en}, 0);
        chk("async_match_start", {31'd0, bus.match_start}, 0);
        chk("async_res_valid", {31'd0, bus.res_valid}, 0);
        chk("async_res_hit", {31'd0, bus.res_hit}, 0);
        chk("async_res_len", {28'd0, bus.res_len}, 0);
        chk("async_res_ovf", {31'd0, bus.res_ovf}, 0);
        m_fill = 0;
        m_ptr  = 0;
        m_ovf  = 0;
        @(posedge clk); #1;
        rst_n           = 1'b1;
        bus.match_done  = 1'b1;
        bus.match_equal = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abandoned_no_res", {31'd0, bus.res_valid}, 0);
        end
        @(posedge clk); #1;
        bus.match_done  = 1'b0;
        bus.match_equal = 1'b0;
        @(posedge clk); #1;

        chk("sb_wr_drained", sb_wr.size(), 0);
        chk("sb_res_drained", sb_res.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/word_loader.md
WORD_LOADER -- requirements
Module: word_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, word-buffer address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, character width.
REQ-003 SHALL have parameter DELIM, default 8'h20, word-delimiter character.
REQ-004 SHALL have port clk  in  1  clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports in_valid / in_data / in_last  in  1 / DATA_WIDTH / 1  character stream; in_last marks end of stream.
REQ-007 SHALL have port in_ready  out  1  stream accept.
REQ-008 SHALL have ports wr_en / wr_addr / wr_data  out  1 / ADDR_WIDTH / DATA_WIDTH  word-buffer SRAM write port.
REQ-009 SHALL have ports match_start  out  1, match_done  in  1, match_equal  in  1; matcher control.
REQ-010 SHALL have ports res_valid  out  1, res_ready  in  1, res_hit  out  1, res_len  out  ADDR_WIDTH, res_ovf  out  1; result handshake.

Function
REQ-011 SHALL accept a character only on a cycle with in_valid && in_ready.
REQ-012 SHALL implement FSM IDLE, FILL, TERM, MATCH, RESP.
REQ-013 IDLE: in_ready=1; accepted DELIM or NUL dropped (leading-space skip); any other character written to addr 0, ptr<=1, go FILL; accepted in_last with a non-delimiter goes TERM instead.
REQ-014 FILL: in_ready=1; non-delimiter written to addr ptr, ptr+1, while ptr < 2^ADDR_WIDTH-1.
REQ-015 FILL: non-delimiter accepted at ptr = 2^ADDR_WIDTH-1 SHALL NOT be written; sticky ovf set; ptr held (last slot reserved for terminator).
REQ-016 FILL: accepted DELIM, or any accepted byte with in_last (written first if a non-delimiter and room remains), goes TERM.
REQ-017 TERM: in_ready=0; write NUL (0) at addr ptr; go MATCH next cycle.
REQ-018 MATCH: in_ready=0; match_start=1 for exactly the first MATCH cycle; wait for match_done=1.
REQ-019 On match_done=1 in MATCH: res_hit <= match_equal && !ovf; res_len <= ptr; res_ovf <= ovf; go RESP.
REQ-020 RESP: res_valid=1, result fields stable; on res_ready=1 go IDLE, clear ptr and ovf.
REQ-021 wr_en SHALL be high only in the cycle of a write (REQ-013/014/016/017); wr_addr/wr_data don't-care otherwise.
REQ-022 match_done arriving outside MATCH SHALL be ignored.
REQ-023 Latency: delimiter accept -> TERM write 1 cycle -> match_start 1 cycle later; match_done -> res_valid next cycle.
REQ-024 res_ready while res_valid=0 SHALL be ignored.

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE, ptr=0, ovf=0, in_ready=0 until first clk after release, wr_en=0, match_start=0, res_valid=0, res_hit=0, res_len=0, res_ovf=0.
REQ-026 Reset mid-word or mid-match SHALL abandon the token; no result emitted for it.

Structure
REQ-027 Shared package word_pkg SHALL hold the FSM state enum, NUL constant, and DELIM default; word_loader and the matcher import it.
REQ-028 No sub-module; word-buffer SRAM and matcher are instantiated by the parent.

Verification
REQ-029 Stream "cat " (ADDR_WIDTH=4) -> writes c@0,a@1,t@2,0@3; match_start one pulse; match_done=1,equal=1 -> res_hit=1, res_len=3, res_ovf=0.
REQ-030 Stream "  dog" with in_last on 'g' -> leading spaces dropped, writes d@0,o@1,g@2,0@3; equal=0 -> res_hit=0, res_len=3.
REQ-031 20 non-delimiter chars then " " -> 15 chars written @0..14, 0@15, res_ovf=1, res_len=15, res_hit=0 even with match_equal=1.
REQ-032 res_ready held low 5 cycles in RESP -> res_valid and fields stable, in_ready=0; res_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-033 rst_n pulsed low in MATCH -> all outputs at reset values immediately; later match_done=1 produces no res_valid.
REQ-034 match_done=1 asserted in IDLE -> ignored, no res_valid; back-to-back words "a b " -> two results in order, res_len=1 each.
